// File: rtl/cpu_run_ctrl.sv
// Run/halt/step/breakpoint controller that gates the CPU core clock enable.
// Also debounces the step button and counts executed cycles.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic             halt_req,
    input  logic             clr_cnt,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2,
        StHalt = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              sync1_q, sync2_q;
    logic              db_q, db_d;
    logic              db_dly_q;
    logic [15:0]       db_cnt_q, db_cnt_d;
    logic [16:0]       db_cnt_inc;
    logic              step_pulse;
    logic              bp_match;

    // Debounce: the synchronized level must disagree with db for DEBOUNCE_CYCLES edges.
    always_comb begin
        db_d       = db_q;
        db_cnt_d   = 16'd0;
        db_cnt_inc = {1'b0, db_cnt_q} + 17'd1;
        if (sync2_q != db_q) begin
            if (db_cnt_inc == 17'(DEBOUNCE_CYCLES)) begin
                db_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_inc[15:0];
            end
        end
    end

    assign step_pulse = db_q & ~db_dly_q;
    assign bp_match   = bp_en && (pc == bp_addr);

    always_comb begin
        cpu_en = 1'b0;
        if ((state_q == StRun) && !bp_match && !halt_req) begin
            cpu_en = 1'b1;
        end else if (state_q == StStep) begin
            cpu_en = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        bp_hit_d = bp_hit_q;
        unique case (state_q)
            StIdle: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (run_sw) begin
                    state_d = StRun;
                end else if (step_pulse) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (bp_match) begin
                    state_d  = StHalt;
                    bp_hit_d = 1'b1;
                end else if (!run_sw) begin
                    state_d = StIdle;
                end
            end
            StStep: begin
                state_d = StIdle;
            end
            StHalt: begin
                if (!run_sw && !halt_req) begin
                    state_d  = StIdle;
                    bp_hit_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (clr_cnt) begin
            cycle_count_d = '0;
        end else if (cpu_en) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            bp_hit_q      <= 1'b0;
            cycle_count_q <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_q          <= 1'b0;
            db_dly_q      <= 1'b0;
            db_cnt_q      <= 16'd0;
        end else begin
            state_q       <= state_d;
            bp_hit_q      <= bp_hit_d;
            cycle_count_q <= cycle_count_d;
            sync1_q       <= step_btn;
            sync2_q       <= sync1_q;
            db_q          <= db_d;
            db_dly_q      <= db_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    assign state       = state_q;
    assign bp_hit      = bp_hit_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Execution controller that sequences the single-cycle CPU core inside Top. It sits between the board switches/button and the core's clock-enable input.
- Provides four modes: run, halt, single-step from a debounced button, and PC breakpoint.
- Keeps a count of executed cycles for LED/debug display.
- The core advances only in cycles where cpu_en=1.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized button level must differ from the accepted level before it is accepted; legal range 1..65535.
- CNT_W, 32, width of cycle_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; everything clears while low.
- run_sw  in  1  level switch; 1 = free-run requested.
- step_btn  in  1  raw asynchronous push-button; each accepted press executes one instruction.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC.
- pc  in  32  current PC from core.
- halt_req  in  1  core fault/halt request (e.g. undefined opcode), level.
- clr_cnt  in  1  synchronous clear of cycle_count.
- cpu_en  out  1  core clock enable.
- state  out  2  0=IDLE, 1=RUN, 2=STEP, 3=HALT.
- bp_hit  out  1  sticky; HALT was entered via the breakpoint.
- cycle_count  out  CNT_W  executed-cycle counter.

Behaviour:
- Reset values (reset low):
  - state=IDLE, cpu_en=0, bp_hit=0, cycle_count=0.
  - Synchronizer flops, debounced level, its delayed copy and debounce counter all 0.
- Button path:
  - 2-flop synchronizer produces s.
  - Debounce counter increments each edge while s!=db and resets to 0 whenever s==db.
  - db toggles on the edge where the counter would reach DEBOUNCE_CYCLES; the counter then returns to 0.
  - step_pulse = db & ~db_d, where db_d is db registered one cycle. This gives exactly one pulse per accepted press; release produces no pulse.
  - A button held through reset release produces one pulse once it has debounced.
- bp_match = bp_en && (pc == bp_addr), full 32-bit compare.
- cpu_en is combinational: 1 when (state==RUN && !bp_match && !halt_req) or state==STEP; otherwise 0. The instruction at the breakpoint PC is not executed in RUN.
- Transitions, evaluated on the rising edge in priority order:
  - IDLE: halt_req -> HALT; else run_sw -> RUN; else step_pulse -> STEP; else stay.
  - RUN: halt_req -> HALT (bp_hit stays 0); else bp_match -> HALT with bp_hit<=1; else !run_sw -> IDLE; else stay.
  - STEP: always -> IDLE after exactly one cycle. bp_match and halt_req are ignored during STEP, so a step from a breakpoint executes the breakpoint instruction.
  - HALT: exits to IDLE only when run_sw==0 and halt_req==0; bp_hit<=0 on that exit. step_pulse is ignored in HALT.
- step_pulse arriving in RUN, STEP or HALT is dropped, not queued.
- Simultaneous run_sw rise and step_pulse in IDLE: RUN wins.
- cycle_count:
  - Increments by 1 on each edge where cpu_en==1.
  - Wraps from all-ones to 0 with no flag.
  - clr_cnt has priority: if clr_cnt==1 the next value is 0 even when cpu_en==1.
- Reset asserted mid-RUN or mid-STEP:
  - cpu_en drops immediately (asynchronous) and all state clears.
  - After reset release the block remains in IDLE until it sees run_sw or a new step_pulse.

Test Plan:
- Reset, run_sw=0, step_btn=0 for 20 cycles -> state=0, cpu_en=0, cycle_count=0 throughout.
- DEBOUNCE_CYCLES=4: step_btn sampled high at edge 0 and held 30 cycles -> state=2 after edge 6, cpu_en=1 for exactly that one cycle, cycle_count=1, state=0 after edge 7. A 3-cycle glitch on step_btn -> no step.
- run_sw=1, bp_en=1, bp_addr=0x0000000C, pc advancing 0,4,8,C -> cpu_en=1 for 3 cycles and 0 when pc=0xC; state=3, bp_hit=1, cycle_count=3. Then run_sw=0 -> state=0, bp_hit=0. Then one step -> cpu_en pulses once at pc=0xC, cycle_count=4.
- In RUN, assert halt_req for 1 cycle -> cpu_en=0 that cycle, state=3, bp_hit=0. State stays 3 while run_sw=1; run_sw=0 -> IDLE.
- Preload via run so cycle_count=0xFFFFFFFF, run 1 more cycle -> 0. Assert clr_cnt together with cpu_en=1 -> 0.
- Pull reset low mid-RUN with cycle_count=5 -> cpu_en=0 immediately and state=0, cycle_count=0. After release with run_sw=1 -> RUN on the next edge.
